road_step_ctrl: RTL and testbench

- Sequencer for the road-cell traffic datapath (30-car, 20-cell road with jam detection).
- Divides i_clk into simulation step ticks and issues one step request per tick to the datapath over a req/ack handshake.
- Schedules car injection into entry cell 1 using a fixed velocity pattern, and halts the run on a datapath jam flag.
- Handles start/pause/single-step/auto-restart. Sits between board clock/buttons and the road datapath.

---
 rtl/road_step_ctrl_if.sv | 29 ++
 rtl/road_step_ctrl.sv | 156 +++++++++++++++
 tb/tb_road_step_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/road_step_ctrl_if.sv
// Handshake and status bundle between the step sequencer and the road datapath.
// The sequencer owns the master view; the datapath (or bench) owns the slave view.
interface road_step_ctrl_if;
  // Board buttons and datapath handshake inputs to the sequencer
  logic        start;
  logic        pause;
  logic        single;
  logic        step_ack;
  logic        jam;
  logic        entry_busy;
  // Sequencer outputs
  logic        clear;
  logic        step_req;
  logic        inject;
  logic [3:0]  inj_vel;
  logic [4:0]  car_cnt;
  logic [10:0] step_cnt;
  logic [2:0]  state;

  modport master (
    input  start, pause, single, step_ack, jam, entry_busy,
    output clear, step_req, inject, inj_vel, car_cnt, step_cnt, state
  );

  modport slave (
    output start, pause, single, step_ack, jam, entry_busy,
    input  clear, step_req, inject, inj_vel, car_cnt, step_cnt, state
  );
endinterface

// File: rtl/road_step_ctrl.sv
// Step sequencer for the road-cell traffic datapath: divides the clock into
// step ticks, issues one req/ack step per tick, schedules car injection into
// entry cell 1 and halts (optionally auto-restarting) on a datapath jam.
module road_step_ctrl #(
  parameter int unsigned DIV          = 25000000,
  parameter int unsigned INJ_PERIOD   = 2,
  parameter int unsigned NUM_CARS     = 30,
  parameter int unsigned MAX_STEPS    = 1000,
  parameter int unsigned HOLD_TICKS   = 8,
  parameter int unsigned AUTO_RESTART = 1
) (
  input  logic              i_clk,
  input  logic              reset,
  road_step_ctrl_if.master  bus
);

  localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    BUSY  = 3'd3,
    JAM   = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [25:0]  presc;
  logic [10:0]  step_cnt;
  logic [10:0]  phase;      // step_cnt mod INJ_PERIOD, kept incrementally
  logic [4:0]   car_cnt;
  logic [HW-1:0] hold_cnt;
  logic         inj_pend;
  logic         inject_q;
  logic [3:0]   inj_vel_q;

  logic         presc_run;
  logic         tick;
  logic         issue;
  logic         ack;
  logic         due;
  logic         room;
  logic         do_inject;
  logic [3:0]   vel_sel;
  logic [10:0]  step_next;

  // Prescaler only advances while a run is live and not paused; tick is its wrap.
  assign presc_run = (state_q inside {RUN, BUSY, JAM}) && !bus.pause;
  assign tick      = presc_run && (presc == 26'(DIV - 1));
  // Tick and single are mutually exclusive (tick needs pause=0), so at most one step issues.
  assign issue     = (state_q == RUN) && (tick || (bus.pause && bus.single));
  assign ack       = (state_q == BUSY) && bus.step_ack;
  assign step_next = step_cnt + 11'd1;

  assign due       = (phase == 11'd0) || inj_pend;
  assign room      = car_cnt < 5'(NUM_CARS);
  assign do_inject = due && room && !bus.entry_busy;

  // Fixed velocity pattern 3,2,1,4 indexed by the number of cars already injected.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    vel_sel = 4'd0;
    case (car_cnt[1:0])
      2'd0: vel_sel = 4'd3;
      2'd1: vel_sel = 4'd2;
      2'd2: vel_sel = 4'd1;
      2'd3: vel_sel = 4'd4;
      default: vel_sel = 4'd0;
    endcase
  end

  // Next-state logic; jam on the acknowledged step wins over end-of-run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN:   if (issue) state_d = BUSY;
      BUSY: begin
        if (ack) begin
          if (bus.jam)                             state_d = JAM;
          else if (step_next == 11'(MAX_STEPS))    state_d = IDLE;
          else                                     state_d = RUN;
        end
      end
      JAM: begin
        if (bus.start)
          state_d = CLEAR;
        else if ((AUTO_RESTART != 0) && tick && (hold_cnt == HW'(HOLD_TICKS - 1)))
          state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Counters, prescaler and the injection decision latched at step issue.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      presc     <= '0;
      step_cnt  <= '0;
      phase     <= '0;
      car_cnt   <= '0;
      hold_cnt  <= '0;
      inj_pend  <= 1'b0;
      inject_q  <= 1'b0;
      inj_vel_q <= '0;
    end else if (state_q == CLEAR) begin
      presc     <= '0;
      step_cnt  <= '0;
      phase     <= '0;
      car_cnt   <= '0;
      hold_cnt  <= '0;
      inj_pend  <= 1'b0;
      inject_q  <= 1'b0;
      inj_vel_q <= '0;
    end else begin
      if (presc_run)
        presc <= (presc == 26'(DIV - 1)) ? 26'd0 : presc + 26'd1;

      if (issue) begin
        inject_q  <= do_inject;
        inj_vel_q <= do_inject ? vel_sel : 4'd0;
        // A due injection blocked by an occupied entry cell is retried next step.
        if (due && room)
          inj_pend <= bus.entry_busy;
      end

      if (ack) begin
        step_cnt  <= step_next;
        car_cnt   <= car_cnt + {4'd0, inject_q};
        phase     <= (phase == 11'(INJ_PERIOD - 1)) ? 11'd0 : phase + 11'd1;
        inject_q  <= 1'b0;
        inj_vel_q <= 4'd0;
      end

      if ((state_q == JAM) && tick)
        hold_cnt <= hold_cnt + HW'(1);
    end
  end

  assign bus.clear    = (state_q == CLEAR);
  assign bus.step_req = (state_q == BUSY);
  assign bus.inject   = inject_q;
  assign bus.inj_vel  = inj_vel_q;
  assign bus.car_cnt  = car_cnt;
  assign bus.step_cnt = step_cnt;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_road_step_ctrl.sv
// Bench for road_step_ctrl: table-driven runs plus hand-written pause/single,
// jam/auto-restart and reset-during-request sequences.
module tb_road_step_ctrl;

  localparam int DIV        = 4;
  localparam int INJ_PERIOD = 2;
  localparam int NUM_CARS   = 3;
  localparam int MAX_STEPS  = 6;
  localparam int HOLD_TICKS = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_JAM   = 3'd4;

  logic i_clk = 1'b0;
  logic reset;

  road_step_ctrl_if bus ();

  road_step_ctrl #(
    .DIV          (DIV),
    .INJ_PERIOD   (INJ_PERIOD),
    .NUM_CARS     (NUM_CARS),
    .MAX_STEPS    (MAX_STEPS),
    .HOLD_TICKS   (HOLD_TICKS),
    .AUTO_RESTART (1)
  ) dut (
    .i_clk (i_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        busy;       // entry_busy during this step's issue
    logic        jam;        // jam flag returned with the ack
    logic        by_single;  // issue via single pulse (pause already 1)
    int          ack_wait;   // cycles from step_req rise to ack
    logic        inj;        // expected inject
    logic [3:0]  vel;        // expected inj_vel
    logic [4:0]  car;        // expected car_cnt after ack
    logic [10:0] steps;      // expected step_cnt after ack
    logic [2:0]  st;         // expected state after ack
  } step_t;

  step_t exp_q[$];
  step_t run1 [6];
  step_t run2 [6];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge i_clk);
      cyc++;
    end while (!bus.step_req && cyc < 100);
    check("step_req_seen", 32'(bus.step_req), 1);
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(negedge i_clk);
    bus.start = 1'b0;
    check("clear_pulse", 32'(bus.clear), 1);
    check("clear_state", 32'(bus.state), 32'(S_CLEAR));
    @(negedge i_clk);
    check("clear_one_cycle", 32'(bus.clear), 0);
    check("run_entry", 32'(bus.state), 32'(S_RUN));
  endtask

  task automatic do_step(input step_t r, output int cyc);
    step_t e;
    int high;
    bus.entry_busy = r.busy;
    exp_q.push_back(r);
    if (r.by_single) begin
      bus.single = 1'b1;
      @(negedge i_clk);
      bus.single = 1'b0;
      cyc = 1;
      check("single_issue", 32'(bus.step_req), 1);
    end else begin
      wait_req(cyc);
    end
    e = exp_q.pop_front();
    check("inject", 32'(bus.inject), 32'(e.inj));
    check("inj_vel", 32'(bus.inj_vel), 32'(e.vel));
    high = 0;
    for (int i = 1; i < e.ack_wait; i++) begin
      @(negedge i_clk);
      if (bus.step_req) high++;
    end
    check("req_held", high, e.ack_wait - 1);
    bus.step_ack = 1'b1;
    bus.jam      = e.jam;
    @(negedge i_clk);
    bus.step_ack   = 1'b0;
    bus.jam        = 1'b0;
    bus.entry_busy = 1'b0;
    check("req_drop", 32'(bus.step_req), 0);
    check("inject_drop", 32'(bus.inject), 0);
    check("car_cnt", 32'(bus.car_cnt), 32'(e.car));
    check("step_cnt", 32'(bus.step_cnt), 32'(e.steps));
    check("state_after_ack", 32'(bus.state), 32'(e.st));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int high;
    logic frozen;
    step_t r;

    //             busy  jam   sgl  ackw inj   vel    car    steps   state
    run1[0] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 4'd3, 5'd1, 11'd1, S_RUN};
    run1[1] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 5'd1, 11'd2, S_RUN};
    run1[2] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 4'd2, 5'd2, 11'd3, S_RUN};
    run1[3] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 5'd2, 11'd4, S_RUN};
    run1[4] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 4'd1, 5'd3, 11'd5, S_RUN};
    run1[5] = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 5'd3, 11'd6, S_IDLE};

    run2[0] = '{1'b0, 1'b0, 1'b0,  2, 1'b1, 4'd3, 5'd1, 11'd1, S_RUN};
    run2[1] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 4'd0, 5'd1, 11'd2, S_RUN};
    run2[2] = '{1'b1, 1'b0, 1'b0,  2, 1'b0, 4'd0, 5'd1, 11'd3, S_RUN};
    run2[3] = '{1'b0, 1'b0, 1'b0,  2, 1'b1, 4'd2, 5'd2, 11'd4, S_RUN};
    run2[4] = '{1'b0, 1'b0, 1'b0,  2, 1'b1, 4'd1, 5'd3, 11'd5, S_RUN};
    run2[5] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 4'd0, 5'd3, 11'd6, S_IDLE};

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.single     = 1'b0;
    bus.step_ack   = 1'b0;
    bus.jam        = 1'b0;
    bus.entry_busy = 1'b0;
    repeat (3) @(negedge i_clk);

    // Reset state
    check("rst_state", 32'(bus.state), 32'(S_IDLE));
    check("rst_clear", 32'(bus.clear), 0);
    check("rst_req", 32'(bus.step_req), 0);
    check("rst_inject", 32'(bus.inject), 0);
    check("rst_vel", 32'(bus.inj_vel), 0);
    check("rst_car", 32'(bus.car_cnt), 0);
    check("rst_step", 32'(bus.step_cnt), 0);
    reset = 1'b0;

    // IDLE ignores everything but start
    bus.pause = 1'b1; bus.single = 1'b1; bus.step_ack = 1'b1; bus.jam = 1'b1;
    @(negedge i_clk);
    bus.pause = 1'b0; bus.single = 1'b0; bus.step_ack = 1'b0; bus.jam = 1'b0;
    @(negedge i_clk);
    check("idle_ignore_state", 32'(bus.state), 32'(S_IDLE));
    check("idle_ignore_req", 32'(bus.step_req), 0);

    // Run 1: free entry cell, injections saturate at NUM_CARS, ends at MAX_STEPS
    start_run();
    for (int i = 0; i < 6; i++) begin
      do_step(run1[i], cyc);
      if (i == 0) check("first_req_latency", cyc, DIV);
    end

    // Run 2: blocked entry at step 2 becomes pending; long-held ack at step 1
    start_run();
    for (int i = 0; i < 6; i++) do_step(run2[i], cyc);

    // Run 3: pause holds prescaler, single with pause=0 ignored, single steps once, jam
    start_run();
    bus.pause = 1'b1;
    high = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (bus.step_req) high++;
    end
    check("pause_no_req", high, 0);
    bus.pause = 1'b0;
    r = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 4'd3, 5'd1, 11'd1, S_RUN};
    do_step(r, cyc);
    check("presc_held_latency", cyc, DIV);

    bus.single = 1'b1;
    @(negedge i_clk);
    bus.single = 1'b0;
    check("single_unpaused_ignored", 32'(bus.step_req), 0);
    r = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 4'd0, 5'd1, 11'd2, S_RUN};
    do_step(r, cyc);

    bus.pause = 1'b1;
    high = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (bus.step_req) high++;
    end
    check("pause_before_single", high, 0);
    r = '{1'b0, 1'b1, 1'b1, 2, 1'b1, 4'd2, 5'd2, 11'd3, S_JAM};
    do_step(r, cyc);
    bus.pause = 1'b0;

    // JAM: counters frozen until auto-restart after HOLD_TICKS ticks
    cyc = 0;
    frozen = 1'b1;
    do begin
      @(negedge i_clk);
      cyc++;
      if (!bus.clear && (bus.step_cnt != 11'd3 || bus.state != S_JAM || bus.step_req)) frozen = 1'b0;
    end while (!bus.clear && cyc < 40);
    check("jam_frozen", 32'(frozen), 1);
    check("hold_clear_seen", 32'(bus.clear), 1);
    check("hold_tick_window", 32'((cyc >= (HOLD_TICKS - 1) * DIV + 1) && (cyc <= HOLD_TICKS * DIV)), 1);
    @(negedge i_clk);
    check("restart_state", 32'(bus.state), 32'(S_RUN));
    check("restart_step", 32'(bus.step_cnt), 0);
    check("restart_car", 32'(bus.car_cnt), 0);

    // Reset during an outstanding request
    wait_req(cyc);
    reset = 1'b1;
    @(negedge i_clk);
    check("rst_busy_req", 32'(bus.step_req), 0);
    check("rst_busy_state", 32'(bus.state), 32'(S_IDLE));
    check("rst_busy_inject", 32'(bus.inject), 0);
    reset = 1'b0;
    @(negedge i_clk);
    check("post_rst_idle", 32'(bus.state), 32'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
